set_job_scheduler: RTL and testbench

SET_JOB_SCHEDULER -- requirements
Module: set_job_scheduler

---
 rtl/set_sched_pkg.sv | 30 +++
 rtl/set_job_scheduler_if.sv | 39 +++
 rtl/set_rr_arb.sv | 19 +
 rtl/set_job_scheduler.sv | 138 +++++++++++++
 tb/tb_set_job_scheduler.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/set_sched_pkg.sv
// Shared types, mode encodings and field widths for the set-count job scheduler.
package set_sched_pkg;

    localparam int unsigned TIMEOUT_DEF = 100;
    localparam int unsigned NUM_REQ     = 2;
    localparam int unsigned CENTRAL_W   = 24;
    localparam int unsigned RADIUS_W    = 12;
    localparam int unsigned MODE_W      = 2;
    localparam int unsigned CAND_W      = 8;
    localparam int unsigned CNT_W       = 7;

    localparam logic [MODE_W-1:0] IN_C0   = 2'd0;
    localparam logic [MODE_W-1:0] AND_C01 = 2'd1;
    localparam logic [MODE_W-1:0] XOR_C01 = 2'd2;
    localparam logic [MODE_W-1:0] RSVD    = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWait,
        StDone
    } state_e;

    typedef struct packed {
        logic [CENTRAL_W-1:0] central;
        logic [RADIUS_W-1:0]  radius;
        logic [MODE_W-1:0]    mode;
    } job_t;

endpackage

// File: rtl/set_job_scheduler_if.sv
// Requester, engine and result signals of the job scheduler, grouped for port passing.
interface set_job_scheduler_if;
    import set_sched_pkg::*;

    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   ready;
    logic [CENTRAL_W-1:0] central0;
    logic [CENTRAL_W-1:0] central1;
    logic [RADIUS_W-1:0]  radius0;
    logic [RADIUS_W-1:0]  radius1;
    logic [MODE_W-1:0]    mode0;
    logic [MODE_W-1:0]    mode1;
    logic                 eng_en;
    logic [CENTRAL_W-1:0] eng_central;
    logic [RADIUS_W-1:0]  eng_radius;
    logic [MODE_W-1:0]    eng_mode;
    logic                 eng_busy;
    logic                 eng_valid;
    logic [CAND_W-1:0]    eng_candidate;
    logic                 res_valid;
    logic                 res_id;
    logic                 res_err;
    logic [CAND_W-1:0]    res_candidate;

    modport slave (
        input  req, central0, central1, radius0, radius1, mode0, mode1,
        input  eng_busy, eng_valid, eng_candidate,
        output ready, eng_en, eng_central, eng_radius, eng_mode,
        output res_valid, res_id, res_err, res_candidate
    );

    modport master (
        output req, central0, central1, radius0, radius1, mode0, mode1,
        output eng_busy, eng_valid, eng_candidate,
        input  ready, eng_en, eng_central, eng_radius, eng_mode,
        input  res_valid, res_id, res_err, res_candidate
    );

endinterface

// File: rtl/set_rr_arb.sv
// Two-way round-robin selector: the slot at i_rr_ptr wins when full, else the other one.
module set_rr_arb
    import set_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_rr_ptr,
    output logic               o_gnt_idx,
    output logic               o_gnt_vld
);

    always_comb begin
        o_gnt_vld = |i_req;
        o_gnt_idx = i_rr_ptr;
        if (!i_req[i_rr_ptr]) begin
            o_gnt_idx = ~i_rr_ptr;
        end
    end

endmodule

// File: rtl/set_job_scheduler.sv
// Two-slot job scheduler: round-robin dispatch to a set-count engine with timeout and
// reserved-mode rejection.
module set_job_scheduler
    import set_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    set_job_scheduler_if.slave  bus
);

    state_e               r_state;
    logic [NUM_REQ-1:0]   r_full;
    job_t                 r_slot [NUM_REQ];
    logic                 r_rr_ptr;
    logic                 r_sel;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_eng_en;
    logic [CENTRAL_W-1:0] r_eng_central;
    logic [RADIUS_W-1:0]  r_eng_radius;
    logic [MODE_W-1:0]    r_eng_mode;
    logic                 r_res_valid;
    logic                 r_res_id;
    logic                 r_res_err;
    logic [CAND_W-1:0]    r_res_cand;

    logic [NUM_REQ-1:0]   w_accept;
    job_t                 w_in_job [NUM_REQ];
    logic                 w_gnt_idx;
    logic                 w_gnt_vld;
    logic                 w_unused_busy;

    assign w_in_job[0] = '{central: bus.central0, radius: bus.radius0, mode: bus.mode0};
    assign w_in_job[1] = '{central: bus.central1, radius: bus.radius1, mode: bus.mode1};
    // A full slot (including one being cleared this cycle) never accepts.
    assign w_accept      = bus.req & ~r_full;
    // Completion is keyed on eng_valid alone; busy is informational.
    assign w_unused_busy = bus.eng_busy;

    set_rr_arb u_arb (
        .i_req     (r_full),
        .i_rr_ptr  (r_rr_ptr),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_vld (w_gnt_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_full        <= '0;
            r_slot[0]     <= '0;
            r_slot[1]     <= '0;
            r_rr_ptr      <= 1'b0;
            r_sel         <= 1'b0;
            r_cnt         <= '0;
            r_eng_en      <= 1'b0;
            r_eng_central <= '0;
            r_eng_radius  <= '0;
            r_eng_mode    <= '0;
            r_res_valid   <= 1'b0;
            r_res_id      <= 1'b0;
            r_res_err     <= 1'b0;
            r_res_cand    <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_accept[i]) begin
                    r_full[i] <= 1'b1;
                    r_slot[i] <= w_in_job[i];
                end
            end
            r_eng_en    <= 1'b0;
            r_res_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_gnt_vld) begin
                        r_sel <= w_gnt_idx;
                        if (r_slot[w_gnt_idx].mode == RSVD) begin
                            r_state     <= StDone;
                            r_res_valid <= 1'b1;
                            r_res_id    <= w_gnt_idx;
                            r_res_err   <= 1'b1;
                            r_res_cand  <= '0;
                        end else begin
                            r_state       <= StLaunch;
                            r_eng_en      <= 1'b1;
                            r_eng_central <= r_slot[w_gnt_idx].central;
                            r_eng_radius  <= r_slot[w_gnt_idx].radius;
                            r_eng_mode    <= r_slot[w_gnt_idx].mode;
                        end
                    end
                end
                StLaunch: begin
                    r_full[r_sel] <= 1'b0;
                    r_cnt         <= '0;
                    r_state       <= StWait;
                end
                StWait: begin
                    // A result landing on the timeout cycle still wins.
                    if (bus.eng_valid) begin
                        r_state     <= StDone;
                        r_res_valid <= 1'b1;
                        r_res_id    <= r_sel;
                        r_res_err   <= 1'b0;
                        r_res_cand  <= bus.eng_candidate;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_state     <= StDone;
                        r_res_valid <= 1'b1;
                        r_res_id    <= r_sel;
                        r_res_err   <= 1'b1;
                        r_res_cand  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StDone: begin
                    r_rr_ptr <= ~r_sel;
                    if (r_slot[r_sel].mode == RSVD) begin
                        r_full[r_sel] <= 1'b0;
                    end
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.ready         = ~r_full;
    assign bus.eng_en        = r_eng_en;
    assign bus.eng_central   = r_eng_central;
    assign bus.eng_radius    = r_eng_radius;
    assign bus.eng_mode      = r_eng_mode;
    assign bus.res_valid     = r_res_valid;
    assign bus.res_id        = r_res_id;
    assign bus.res_err       = r_res_err;
    assign bus.res_candidate = r_res_cand;

endmodule

// File: tb/tb_set_job_scheduler.sv
// Bench for set_job_scheduler: directed scenarios then randomized jobs against a
// slot/round-robin reference model and a latency-programmable engine model.
module tb_set_job_scheduler;
    import set_sched_pkg::*;

    localparam int T = TIMEOUT_DEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    set_job_scheduler_if bus ();

    set_job_scheduler #(.TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: slot occupancy, pending job fields, round-robin pointer.
    bit          m_full [2];
    logic [23:0] jc [2];
    logic [11:0] jr [2];
    logic [1:0]  jm [2];
    int          m_rr;

    // Engine model: eng_valid arrives eng_lat cycles after eng_en (0 = never).
    int          eng_lat  = 0;
    logic [7:0]  eng_cand = 8'd0;
    int          eng_left = 0;

    always @(negedge clk) begin
        bus.eng_valid = 1'b0;
        if (bus.eng_en === 1'b1) begin
            eng_left = eng_lat;
        end else if (eng_left > 0) begin
            eng_left = eng_left - 1;
            if (eng_left == 0) bus.eng_valid = 1'b1;
        end
        bus.eng_busy      = (eng_left > 0);
        bus.eng_candidate = eng_cand;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick();
        if (m_full[0] && m_full[1]) return m_rr;
        return m_full[1] ? 1 : 0;
    endfunction

    function automatic int rand_lat();
        case ($urandom_range(0, 9))
            0:       return 0;
            1:       return T;
            2:       return T + 1;
            default: return int'($urandom_range(1, 60));
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        m_full[0] = 0;
        m_full[1] = 0;
        m_rr      = 0;
    endtask

    task automatic load(input int s, input logic [23:0] c, input logic [11:0] r,
                        input logic [1:0] m);
        jc[s] = c;
        jr[s] = r;
        jm[s] = m;
        m_full[s] = 1;
        if (s == 0) begin
            bus.central0 = c; bus.radius0 = r; bus.mode0 = m;
        end else begin
            bus.central1 = c; bus.radius1 = r; bus.mode1 = m;
        end
        bus.req[s] = 1'b1;
    endtask

    task automatic accept();
        logic [1:0] was;
        was = bus.req;
        step();
        bus.req = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (was[i]) chk("ready_fall", bus.ready[i], 1'b0);
        end
    endtask

    task automatic load_rand(input int s);
        load(s, 24'($urandom), 12'($urandom), 2'($urandom_range(0, 3)));
    endtask

    // Serve the job the model expects next; t_launch/t_res are cycles since the call.
    task automatic serve(input int lat, input logic [7:0] cand,
                         output int t_launch, output int t_res);
        int id;
        int n_en;
        bit got;
        bit exp_err;
        logic [7:0] exp_cand;
        int exp_t;
        id = pick();
        n_en = 0;
        got = 0;
        t_launch = -1;
        t_res = -1;
        eng_lat = lat;
        eng_cand = cand;
        for (int cyc = 0; cyc < 400 && !got; cyc++) begin
            if (bus.eng_en === 1'b1) begin
                n_en++;
                t_launch = cyc;
                chk("eng_central", bus.eng_central, jc[id]);
                chk("eng_radius", bus.eng_radius, jr[id]);
                chk("eng_mode", bus.eng_mode, jm[id]);
            end
            if (bus.res_valid === 1'b1) begin
                got = 1;
                t_res = cyc;
            end else begin
                step();
            end
        end
        chk("res_seen", got, 1'b1);
        if (got) begin
            if (jm[id] == 2'd3) begin
                exp_err = 1; exp_cand = 8'd0;
                chk("rsvd_no_launch", n_en, 0);
            end else begin
                chk("launch_once", n_en, 1);
                if (lat >= 1 && lat <= T) begin
                    exp_err = 0; exp_cand = cand; exp_t = lat + 1;
                end else begin
                    exp_err = 1; exp_cand = 8'd0; exp_t = T + 1;
                end
                chk("res_time", t_res - t_launch, exp_t);
            end
            chk("res_id", bus.res_id, id);
            chk("res_err", bus.res_err, exp_err);
            chk("res_cand", bus.res_candidate, exp_cand);
            step();
            chk("res_pulse", bus.res_valid, 1'b0);
            chk("res_hold", {bus.res_id, bus.res_err, bus.res_candidate},
                {id[0], exp_err, exp_cand});
            if (jm[id] != 2'd3) chk("eng_hold", bus.eng_mode, jm[id]);
        end
        m_full[id] = 0;
        m_rr = 1 - id;
    endtask

    int tl, tr;
    int acc, nres, bad_fall, hits;
    bit a;

    initial begin
        bus.req = 2'b00;
        bus.central0 = '0; bus.central1 = '0;
        bus.radius0 = '0;  bus.radius1 = '0;
        bus.mode0 = '0;    bus.mode1 = '0;
        bus.eng_valid = 1'b0;
        bus.eng_busy = 1'b0;
        bus.eng_candidate = '0;

        do_reset();
        chk("rst_ready", bus.ready, 2'b11);
        chk("rst_eng", {bus.eng_en, bus.eng_central, bus.eng_radius, bus.eng_mode}, '0);
        chk("rst_res", {bus.res_valid, bus.res_id, bus.res_err, bus.res_candidate}, '0);

        // Simultaneous pair straight after reset: 0 then 1.
        load_rand(0); jm[0] = 2'd0; bus.mode0 = 2'd0;
        load_rand(1); jm[1] = 2'd1; bus.mode1 = 2'd1;
        accept();
        serve(7, 8'h5a, tl, tr);
        chk("pair1_first", bus.res_id, 1'b0);
        serve(12, 8'h33, tl, tr);
        chk("pair1_second", bus.res_id, 1'b1);

        // Single job on requester 0; eng_en lands in the 2nd cycle counting the req cycle.
        load(0, 24'h440000, 12'h300, 2'd0);
        accept();
        serve(65, 8'd29, tl, tr);
        chk("launch_latency", tl + 1, 2);
        chk("job_cand29", bus.res_candidate, 8'd29);

        // Pointer now favours requester 1: second pair served 1 then 0.
        load_rand(0); jm[0] = 2'd2; bus.mode0 = 2'd2;
        load_rand(1); jm[1] = 2'd0; bus.mode1 = 2'd0;
        accept();
        serve(3, 8'h01, tl, tr);
        chk("pair2_first", bus.res_id, 1'b1);
        serve(4, 8'h02, tl, tr);
        chk("pair2_second", bus.res_id, 1'b0);

        // Reserved mode on requester 1 is rejected without touching the engine.
        load(1, 24'h123456, 12'h789, 2'd3);
        accept();
        serve(5, 8'hff, tl, tr);
        chk("rsvd_latency", (tr >= 0 && tr <= 2), 1'b1);

        // Timeout on the first of a pair, then the queued job runs normally.
        load(0, 24'h111111, 12'h222, 2'd1);
        load(1, 24'h333333, 12'h444, 2'd2);
        accept();
        serve(0, 8'h77, tl, tr);
        serve(20, 8'h66, tl, tr);

        // Result on the timeout cycle wins; one cycle later it does not.
        load_rand(1); jm[1] = 2'd1; bus.mode1 = 2'd1;
        accept();
        serve(T, 8'h9c, tl, tr);
        load_rand(0); jm[0] = 2'd0; bus.mode0 = 2'd0;
        accept();
        serve(T + 1, 8'h9d, tl, tr);

        // Reset 10 cycles into WAIT; the engine's late result must be ignored.
        load(0, 24'habcdef, 12'h654, 2'd1);
        accept();
        eng_lat = 30;
        for (int i = 0; i < 10 && bus.eng_en !== 1'b1; i++) step();
        chk("rstwait_launch", bus.eng_en, 1'b1);
        for (int i = 0; i < 11; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_full[0] = 0; m_full[1] = 0; m_rr = 0;
        chk("rstwait_ready", bus.ready, 2'b11);
        chk("rstwait_eng", {bus.eng_en, bus.eng_central, bus.eng_radius, bus.eng_mode}, '0);
        chk("rstwait_res", {bus.res_valid, bus.res_id, bus.res_err, bus.res_candidate}, '0);
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.res_valid !== 1'b0 || bus.eng_en !== 1'b0) hits++;
        end
        chk("rstwait_quiet", hits, 0);
        chk("rstwait_ready2", bus.ready, 2'b11);

        // Requester 0 holds req high: one accept per empty-slot window.
        bus.central0 = 24'h0f0f0f; bus.radius0 = 12'h555; bus.mode0 = 2'd2;
        eng_lat = 3;
        eng_cand = 8'h42;
        acc = 0; nres = 0; bad_fall = 0;
        bus.req[0] = 1'b1;
        for (int i = 0; i < 90; i++) begin
            a = bus.req[0] && bus.ready[0];
            if (a) acc++;
            step();
            if (a && bus.ready[0] !== 1'b0) bad_fall++;
            if (bus.res_valid === 1'b1) nres++;
        end
        bus.req[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.res_valid === 1'b1) nres++;
        end
        chk("held_acc_eq_res", acc, nres);
        chk("held_ready_fall", bad_fall, 0);
        chk("held_progress", acc >= 10, 1'b1);
        chk("held_drained", bus.ready, 2'b11);
        m_rr = 1;

        // Randomized singles and pairs.
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                load_rand(0);
                load_rand(1);
                accept();
                serve(rand_lat(), 8'($urandom), tl, tr);
                serve(rand_lat(), 8'($urandom), tl, tr);
            end else begin
                load_rand(int'($urandom_range(0, 1)));
                accept();
                serve(rand_lat(), 8'($urandom), tl, tr);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
